// File: rtl/mmu_seq.sv
// Command sequencer feeding the 4x4 MMU systolic array: clear, K feeds, skew drain, idle wait.
// Optional batch-norm trigger phase enabled by defining MMU_SEQ_BN_EN.
module mmu_seq #(
    parameter int ACLEN        = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int KW           = 16,
    parameter int DRAIN_CYCLES = 6
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start,
    input  logic [KW-1:0]             k_len,
    input  logic                      op_valid,
    output logic                      op_ready,
    input  logic [4*DATA_WIDTH-1:0]   op_data,
    input  logic [4*DATA_WIDTH-1:0]   op_weight,
    output logic                      mmu_cmd_valid,
    output logic [ACLEN:0]            mmu_cmd,
    output logic [4*DATA_WIDTH-1:0]   mmu_data,
    output logic [4*DATA_WIDTH-1:0]   mmu_weight,
    input  logic                      mmu_busy,
    input  logic                      bn_valid,
    output logic                      seq_busy,
    output logic                      done,
    output logic [31:0]               cycle_cnt
);

    // state  | meaning
    // IDLE   | waiting for start; latches k_len
    // CLEAR  | issues RESET with zero lanes
    // FEED   | one TRIGGER / TRIGGER_LAST per accepted operand beat
    // DRAIN  | DRAIN_CYCLES FORWARD commands to flush the array skew
    // WAIT   | no commands until the array reports idle
    // BN     | issues TRIGGER_BN, then waits for bn_valid
    // FIN    | one-cycle done pulse

    localparam int LW  = 4 * DATA_WIDTH;
    localparam int DCW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    localparam logic [ACLEN:0] CMD_RESET        = (ACLEN+1)'(0);
    localparam logic [ACLEN:0] CMD_TRIGGER      = (ACLEN+1)'(1);
    localparam logic [ACLEN:0] CMD_TRIGGER_LAST = (ACLEN+1)'(2);
    localparam logic [ACLEN:0] CMD_FORWARD      = (ACLEN+1)'(8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_WAIT,
`ifdef MMU_SEQ_BN_EN
        S_BN,
`endif
        S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_rem_q, k_rem_d;
    logic [DCW-1:0]   drain_q, drain_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [ACLEN:0]   cmd_q, cmd_d;
    logic [LW-1:0]    data_q, data_d;
    logic [LW-1:0]    weight_q, weight_d;
    logic [31:0]      cnt_q, cnt_d;

`ifdef MMU_SEQ_BN_EN
    localparam logic [ACLEN:0] CMD_TRIGGER_BN = (ACLEN+1)'(17);
    logic bn_sent_q, bn_sent_d;
`else
    logic unused_bn_valid;
    assign unused_bn_valid = bn_valid;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            k_rem_q     <= '0;
            drain_q     <= '0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= '0;
            data_q      <= '0;
            weight_q    <= '0;
            cnt_q       <= '0;
`ifdef MMU_SEQ_BN_EN
            bn_sent_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            k_rem_q     <= k_rem_d;
            drain_q     <= drain_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            weight_q    <= weight_d;
            cnt_q       <= cnt_d;
`ifdef MMU_SEQ_BN_EN
            bn_sent_q   <= bn_sent_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        k_rem_d     = k_rem_q;
        drain_d     = drain_q;
        cmd_valid_d = 1'b0;
        cmd_d       = cmd_q;
        data_d      = data_q;
        weight_d    = weight_q;
        cnt_d       = cnt_q;
`ifdef MMU_SEQ_BN_EN
        bn_sent_d   = bn_sent_q;
`endif

        if (state_q != S_IDLE && cnt_q != 32'hFFFF_FFFF) begin
            cnt_d = cnt_q + 32'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_rem_d = k_len;
                    cnt_d   = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                cmd_valid_d = 1'b1;
                cmd_d       = CMD_RESET;
                data_d      = '0;
                weight_d    = '0;
                state_d     = (k_rem_q != '0) ? S_FEED : S_WAIT;
            end
            S_FEED: begin
                // no beat: bubble, lanes keep their last value
                if (op_valid) begin
                    cmd_valid_d = 1'b1;
                    data_d      = op_data;
                    weight_d    = op_weight;
                    k_rem_d     = k_rem_q - KW'(1);
                    if (k_rem_q == KW'(1)) begin
                        cmd_d = CMD_TRIGGER_LAST;
                        if (DRAIN_CYCLES == 0) begin
                            state_d = S_WAIT;
                        end else begin
                            state_d = S_DRAIN;
                            drain_d = DCW'(DRAIN_CYCLES);
                        end
                    end else begin
                        cmd_d = CMD_TRIGGER;
                    end
                end
            end
            S_DRAIN: begin
                cmd_valid_d = 1'b1;
                cmd_d       = CMD_FORWARD;
                data_d      = '0;
                weight_d    = '0;
                drain_d     = drain_q - DCW'(1);
                if (drain_q == DCW'(1)) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!mmu_busy) begin
`ifdef MMU_SEQ_BN_EN
                    state_d   = S_BN;
                    bn_sent_d = 1'b0;
`else
                    state_d   = S_FIN;
`endif
                end
            end
`ifdef MMU_SEQ_BN_EN
            S_BN: begin
                if (!bn_sent_q) begin
                    cmd_valid_d = 1'b1;
                    cmd_d       = CMD_TRIGGER_BN;
                    data_d      = '0;
                    weight_d    = '0;
                    bn_sent_d   = 1'b1;
                end else if (bn_valid) begin
                    state_d = S_FIN;
                end
            end
`endif
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign op_ready      = (state_q == S_FEED);
    assign seq_busy      = (state_q != S_IDLE);
    assign done          = (state_q == S_FIN);
    assign mmu_cmd_valid = cmd_valid_q;
    assign mmu_cmd       = cmd_q;
    assign mmu_data      = data_q;
    assign mmu_weight    = weight_q;
    assign cycle_cnt     = cnt_q;

endmodule

// File: tb/tb_mmu_seq.sv
// Scoreboard bench for mmu_seq: a job-level model predicts every command, flag and done pulse.
// Define MMU_SEQ_BN_EN for both bench and RTL to exercise the batch-norm phase.
module tb_mmu_seq;

    localparam int ACLEN = 8;
    localparam int DW    = 32;
    localparam int KW    = 16;
    localparam int D     = 6;
    localparam int LW    = 4 * DW;
    localparam int N     = 96;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              start = 1'b0;
    logic [KW-1:0]     k_len = '0;
    logic              op_valid = 1'b0;
    logic              op_ready;
    logic [LW-1:0]     op_data = '0;
    logic [LW-1:0]     op_weight = '0;
    logic              mmu_cmd_valid;
    logic [ACLEN:0]    mmu_cmd;
    logic [LW-1:0]     mmu_data;
    logic [LW-1:0]     mmu_weight;
    logic              mmu_busy = 1'b0;
    logic              bn_valid = 1'b0;
    logic              seq_busy;
    logic              done;
    logic [31:0]       cycle_cnt;

    mmu_seq #(.ACLEN(ACLEN), .DATA_WIDTH(DW), .KW(KW), .DRAIN_CYCLES(D)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start(start), .k_len(k_len),
        .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data), .op_weight(op_weight),
        .mmu_cmd_valid(mmu_cmd_valid), .mmu_cmd(mmu_cmd), .mmu_data(mmu_data),
        .mmu_weight(mmu_weight), .mmu_busy(mmu_busy), .bn_valid(bn_valid),
        .seq_busy(seq_busy), .done(done), .cycle_cnt(cycle_cnt)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [ACLEN:0] cmd;
        logic [LW-1:0]  d;
        logic [LW-1:0]  w;
        int             cyc;
    } cmd_t;

    cmd_t          cq[$];
    cmd_t          mon_e;
    logic [LW-1:0] last_d = '0;
    logic [LW-1:0] last_w = '0;
    logic          exp_ready = 1'b0;
    logic          exp_busy = 1'b0;
    logic          exp_done = 1'b0;
    logic [31:0]   exp_cnt = '0;
    bit            chk_en = 1'b0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] rnd_lane();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic push(input int cmd, input logic [LW-1:0] d, input logic [LW-1:0] w, input int c);
        cmd_t e;
        e.cmd = (ACLEN+1)'(cmd);
        e.d   = d;
        e.w   = w;
        e.cyc = c;
        cq.push_back(e);
    endtask

    // monitor: pops the expected command whenever the DUT strobes one
    always @(negedge clk_i) begin
        if (!rst_i) begin
            last_d = '0;
            last_w = '0;
        end else if (chk_en) begin
            while (cq.size() > 0 && cq[0].cyc < cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL missing_cmd: cmd %0d due at cycle %0d not seen by cycle %0d",
                         cq[0].cmd, cq[0].cyc, cyc);
                void'(cq.pop_front());
            end
            if (mmu_cmd_valid) begin
                if (cq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL extra_cmd at cycle %0d: got cmd %0d expected none", cyc, mmu_cmd);
                end else begin
                    mon_e = cq.pop_front();
                    check("cmd_cycle", LW'(cyc), LW'(mon_e.cyc));
                    check("cmd_code", LW'(mmu_cmd), LW'(mon_e.cmd));
                    check("cmd_data", mmu_data, mon_e.d);
                    check("cmd_weight", mmu_weight, mon_e.w);
                    last_d = mon_e.d;
                    last_w = mon_e.w;
                end
            end else begin
                check("hold_data", mmu_data, last_d);
                check("hold_weight", mmu_weight, last_w);
            end
            check("op_ready", LW'(op_ready), LW'(exp_ready));
            check("seq_busy", LW'(seq_busy), LW'(exp_busy));
            check("done", LW'(done), LW'(exp_done));
            if (exp_done) check("cycle_cnt", LW'(cycle_cnt), LW'(exp_cnt));
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_cmd_valid"}, LW'(mmu_cmd_valid), '0);
        check({tag, "_cmd"}, LW'(mmu_cmd), '0);
        check({tag, "_data"}, mmu_data, '0);
        check({tag, "_weight"}, mmu_weight, '0);
        check({tag, "_op_ready"}, LW'(op_ready), '0);
        check({tag, "_seq_busy"}, LW'(seq_busy), '0);
        check({tag, "_done"}, LW'(done), '0);
        check({tag, "_cycle_cnt"}, LW'(cycle_cnt), '0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i); #1;
            start     = 1'b0;
            k_len     = KW'($urandom);
            op_valid  = 1'($urandom);
            op_data   = rnd_lane();
            op_weight = rnd_lane();
            mmu_busy  = 1'($urandom);
            bn_valid  = 1'b0;
            exp_ready = 1'b0;
            exp_busy  = 1'b0;
            exp_done  = 1'b0;
        end
    endtask

    // gmode: 0 back-to-back, 1 two bubbles before beat 1, 2 random bubbles.
    // b: extra busy cycles in WAIT. rst_at>0: reset in that drain cycle.
    task automatic run_job(input int k, input int gmode, input int b, input int rst_at,
                           input bit mid_start, input bit fin_start, input int bnr);
        logic          st[N];
        logic [KW-1:0] kl[N];
        logic          ov[N];
        logic [LW-1:0] od[N];
        logic [LW-1:0] ow[N];
        logic          mb[N];
        logic          bv[N];
        logic          er[N];
        logic          eb[N];
        logic          ed[N];
        logic [31:0]   ec[N];
        int c0, fc, s, fin, g;
`ifdef MMU_SEQ_BN_EN
        int bs, v;
`endif
        @(posedge clk_i); #1;
        c0 = cyc;
        for (int r = 0; r < N; r++) begin
            st[r] = 1'b0;  kl[r] = KW'($urandom);  ov[r] = 1'($urandom);
            od[r] = rnd_lane();  ow[r] = rnd_lane();  mb[r] = 1'($urandom);
            bv[r] = 1'b0;  er[r] = 1'b0;  eb[r] = (r != 0);  ed[r] = 1'b0;  ec[r] = '0;
        end
        st[0] = 1'b1;
        kl[0] = KW'(k);
        push(0, '0, '0, c0 + 2);
        fc = 2;
        for (int j = 0; j < k; j++) begin
            if (gmode == 1) g = (j == 1) ? 2 : 0;
            else if (gmode == 2) g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            else g = 0;
            for (int i = 0; i < g; i++) begin
                ov[fc] = 1'b0;
                er[fc] = 1'b1;
                fc++;
            end
            ov[fc] = 1'b1;
            er[fc] = 1'b1;
            push((j == k - 1) ? 2 : 1, od[fc], ow[fc], c0 + fc + 1);
            fc++;
        end
        if (k > 0) begin
            for (int d = 0; d < D; d++) push(8, '0, '0, c0 + fc + d + 1);
            s = fc + D;
        end else begin
            s = 2;
        end
        for (int i = 0; i < b; i++) mb[s + i] = 1'b1;
        mb[s + b] = 1'b0;
`ifdef MMU_SEQ_BN_EN
        bs = s + b + 1;
        push(17, '0, '0, c0 + bs + 1);
        v = bs + 1 + bnr;
        bv[v] = 1'b1;
        fin = v + 1;
`else
        fin = s + b + 1;
`endif
        ed[fin] = 1'b1;
        ec[fin] = 32'(fin - 1);
        if (mid_start) begin
            st[1] = 1'b1;
            st[2] = 1'b1;
        end
        if (fin_start) st[fin] = 1'b1;

        for (int r = 0; r <= fin; r++) begin
            if (r > 0) begin
                @(posedge clk_i); #1;
            end
            start = st[r];  k_len = kl[r];  op_valid = ov[r];  op_data = od[r];
            op_weight = ow[r];  mmu_busy = mb[r];  bn_valid = bv[r];
            exp_ready = er[r];  exp_busy = eb[r];  exp_done = ed[r];  exp_cnt = ec[r];
            if (rst_at > 0 && k > 0 && r == fc + rst_at) begin
                #1 rst_i = 1'b0;
                #1 check_all_zero("async_rst");
                while (cq.size() > 0 && cq[$].cyc >= c0 + r) void'(cq.pop_back());
                start = 1'b0;  op_valid = 1'b0;
                exp_ready = 1'b0;  exp_busy = 1'b0;  exp_done = 1'b0;
                @(posedge clk_i); #3;
                rst_i = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 check_all_zero("reset");
        @(posedge clk_i); #3;
        rst_i  = 1'b1;
        chk_en = 1'b1;
        idle(2);

        run_job(4, 0, 0, 0, 1'b0, 1'b0, 4);
        idle(1);
        run_job(3, 1, 0, 0, 1'b0, 1'b0, 2);
        idle(2);
        run_job(0, 0, 0, 0, 1'b0, 1'b0, 1);
        idle(1);
        run_job(2, 0, 5, 0, 1'b1, 1'b1, 0);
        run_job(1, 0, 1, 0, 1'b0, 1'b0, 3);
        idle(1);
        run_job(5, 0, 0, 2, 1'b0, 1'b0, 0);
        run_job(1, 0, 0, 0, 1'b0, 1'b0, 4);
        idle(2);

        for (int n = 0; n < 20; n++) begin
            run_job(int'($urandom_range(0, 8)), 2, int'($urandom_range(0, 4)), 0,
                    1'($urandom), 1'($urandom), int'($urandom_range(0, 4)));
            if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 3)));
        end

        idle(4);
        check("queue_drained", LW'(cq.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
